// File: rtl/ldlt_seq_ctrl.sv
// Micro-operation sequencer for the fixed-point LDL^T factorization datapath.
// Walks the matrix column by column and hands INIT/ACC/DIAG/OFF ops to the MAC/divider over valid/ready.
module ldlt_seq_ctrl #(
    parameter  int unsigned WORD_LEN = 14,
    parameter  int unsigned NODE_NUM = 1,
    localparam int unsigned IDX_W    = ($clog2(6 * NODE_NUM) > 1) ? $clog2(6 * NODE_NUM) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_op_valid,
    input  logic             i_op_ready,
    output logic [1:0]       o_op_type,
    output logic [IDX_W-1:0] o_i,
    output logic [IDX_W-1:0] o_j,
    output logic [IDX_W-1:0] o_k
);

    // WORD_LEN only sizes the datapath words; it has no effect on sequencing.
    localparam int unsigned N = 6 * NODE_NUM + 0 * WORD_LEN;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_ACC  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_INIT = 2'b00;
    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_DIAG = 2'b10;
    localparam logic [1:0] OP_OFF  = 2'b11;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] k_q;
    logic [IDX_W-1:0] i_nxt;
    logic [IDX_W-1:0] j_nxt;
    logic [IDX_W-1:0] k_nxt;
    logic [1:0]       type_nxt;
    logic             op_valid_nxt;
    logic             xfer;

    // Next-state and next-index logic; o_i/o_j double as the row/column counters.
    always_comb begin
        state_nxt    = state;
        i_nxt        = o_i;
        j_nxt        = o_j;
        k_nxt        = k_q;
        type_nxt     = o_op_type;
        op_valid_nxt = 1'b0;
        xfer         = o_op_valid && i_op_ready;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_INIT;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    k_nxt     = '0;
                end
            end
            S_INIT: begin
                if (xfer) begin
                    k_nxt     = '0;
                    state_nxt = (o_j != '0) ? S_ACC : S_FIN;
                end
            end
            S_ACC: begin
                if (xfer) begin
                    if (k_q == o_j - IDX_W'(1)) begin
                        state_nxt = S_FIN;
                    end else begin
                        k_nxt = k_q + IDX_W'(1);
                    end
                end
            end
            S_FIN: begin
                if (xfer) begin
                    k_nxt = '0;
                    if (o_i != LAST) begin
                        i_nxt     = o_i + IDX_W'(1);
                        state_nxt = S_INIT;
                    end else if (o_j != LAST) begin
                        // next column restarts on its diagonal element
                        j_nxt     = o_j + IDX_W'(1);
                        i_nxt     = o_j + IDX_W'(1);
                        state_nxt = S_INIT;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        case (state_nxt)
            S_INIT: begin
                type_nxt     = OP_INIT;
                op_valid_nxt = 1'b1;
            end
            S_ACC: begin
                type_nxt     = OP_ACC;
                op_valid_nxt = 1'b1;
            end
            S_FIN: begin
                type_nxt     = (i_nxt == j_nxt) ? OP_DIAG : OP_OFF;
                op_valid_nxt = 1'b1;
            end
            default: begin
                type_nxt     = o_op_type;
                op_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            k_q        <= '0;
            o_i        <= '0;
            o_j        <= '0;
            o_k        <= '0;
            o_op_type  <= OP_INIT;
            o_op_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            state      <= state_nxt;
            k_q        <= k_nxt;
            o_i        <= i_nxt;
            o_j        <= j_nxt;
            o_k        <= (state_nxt == S_ACC) ? k_nxt : '0;
            o_op_type  <= type_nxt;
            o_op_valid <= op_valid_nxt;
            o_busy     <= op_valid_nxt;
            o_valid    <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_ldlt_seq_ctrl.sv
// Scoreboard bench for ldlt_seq_ctrl: an N=6 instance and an N=12 instance share one clock.
module tb_ldlt_seq_ctrl;

    typedef struct {
        int t;
        int i;
        int j;
        int k;
    } op_t;

    logic clk;
    logic rst_n;
    logic start;
    logic ready;
    logic sel;

    logic       a_start, a_ready, a_busy, a_valid, a_op_valid;
    logic [1:0] a_type;
    logic [2:0] a_i, a_j, a_k;
    logic       b_start, b_ready, b_busy, b_valid, b_op_valid;
    logic [1:0] b_type;
    logic [3:0] b_i, b_j, b_k;

    logic       v_busy, v_valid, v_op_valid;
    logic [1:0] v_type;
    logic [3:0] v_i, v_j, v_k;

    int   checks;
    int   errors;
    op_t  sb[$];
    op_t  seen[512];

    ldlt_seq_ctrl #(.WORD_LEN(14), .NODE_NUM(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .o_busy(a_busy), .o_valid(a_valid),
        .o_op_valid(a_op_valid), .i_op_ready(a_ready), .o_op_type(a_type),
        .o_i(a_i), .o_j(a_j), .o_k(a_k)
    );

    ldlt_seq_ctrl #(.WORD_LEN(14), .NODE_NUM(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .o_busy(b_busy), .o_valid(b_valid),
        .o_op_valid(b_op_valid), .i_op_ready(b_ready), .o_op_type(b_type),
        .o_i(b_i), .o_j(b_j), .o_k(b_k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_start = start & ~sel;
    assign a_ready = ready & ~sel;
    assign b_start = start & sel;
    assign b_ready = ready & sel;

    always_comb begin
        if (sel) begin
            v_busy = b_busy; v_valid = b_valid; v_op_valid = b_op_valid;
            v_type = b_type; v_i = b_i; v_j = b_j; v_k = b_k;
        end else begin
            v_busy = a_busy; v_valid = a_valid; v_op_valid = a_op_valid;
            v_type = a_type; v_i = {1'b0, a_i}; v_j = {1'b0, a_j}; v_k = {1'b0, a_k};
        end
    end

    // Reference op stream, column-major: diagonal first, then rows below it.
    task automatic build_model(input int n);
        op_t o;
        sb.delete();
        for (int j = 0; j < n; j++) begin
            for (int i = j; i < n; i++) begin
                o.t = 0; o.i = i; o.j = j; o.k = 0;
                sb.push_back(o);
                for (int k = 0; k < j; k++) begin
                    o.t = 1; o.k = k;
                    sb.push_back(o);
                end
                o.t = (i == j) ? 2 : 3; o.k = 0;
                sb.push_back(o);
            end
        end
    endtask

    // Starts one run and follows it to the cycle after o_valid; e counts edges after the start edge.
    task automatic run_stream(input bit sel_b, input bit stall, input int restart_op,
                              input bit start_in_valid, output int valid_e, output int xfers);
        int  e;
        int  nvalid;
        bit  hold;
        op_t held;
        op_t got;
        op_t exp_op;
        sel = sel_b;
        build_model(sel_b ? 12 : 6);
        nvalid = 0; valid_e = -1; xfers = 0; hold = 0; e = 0;
        start = 1'b1; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        forever begin
            start = 1'b0;
            ready = stall ? (e % 2 == 0) : 1'b1;
            got.t = int'(v_type); got.i = int'(v_i); got.j = int'(v_j); got.k = int'(v_k);
            if (hold) begin
                checks++;
                if (!v_op_valid || got.t !== held.t || got.i !== held.i || got.j !== held.j || got.k !== held.k) begin
                    errors++;
                    $display("FAIL stall_hold e=%0d: got v=%0b t=%0d i=%0d j=%0d k=%0d expected v=1 t=%0d i=%0d j=%0d k=%0d",
                             e, v_op_valid, got.t, got.i, got.j, got.k, held.t, held.i, held.j, held.k);
                end
            end
            hold = 0;
            checks++;
            if (v_busy !== v_op_valid) begin
                errors++;
                $display("FAIL busy_eq_valid e=%0d: got busy=%0b expected %0b", e, v_busy, v_op_valid);
            end
            if (restart_op > 0 && v_op_valid && xfers == restart_op - 1) start = 1'b1;
            if (v_op_valid && ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL op_extra[%0d]: got t=%0d i=%0d j=%0d k=%0d expected no op", xfers, got.t, got.i, got.j, got.k);
                end else begin
                    exp_op = sb.pop_front();
                    if (got.t !== exp_op.t || got.i !== exp_op.i || got.j !== exp_op.j || got.k !== exp_op.k) begin
                        errors++;
                        $display("FAIL op_seq[%0d]: got t=%0d i=%0d j=%0d k=%0d expected t=%0d i=%0d j=%0d k=%0d",
                                 xfers, got.t, got.i, got.j, got.k, exp_op.t, exp_op.i, exp_op.j, exp_op.k);
                    end
                end
                if (xfers < 512) seen[xfers] = got;
                xfers++;
            end else if (v_op_valid) begin
                hold = 1;
                held = got;
            end
            if (v_valid) begin
                nvalid++;
                if (valid_e < 0) valid_e = e;
                if (start_in_valid) start = 1'b1;
            end else if (valid_e >= 0) begin
                checks++;
                if (v_op_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_after_done: got op_valid=%0b expected 0", v_op_valid);
                end
                break;
            end
            if (e > 2000) begin
                errors++;
                $display("FAIL run_timeout: got no o_valid within %0d cycles expected one", e);
                break;
            end
            e++;
            @(negedge clk);
        end
        checks++;
        if (nvalid != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL run_counts: got valid_pulses=%0d ops_left=%0d expected 1 and 0", nvalid, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_busy, a_valid, a_op_valid, a_type, a_i, a_j, a_k} !== 14'd0) begin
            errors++;
            $display("FAIL reset_a: got %b expected all zero", {a_busy, a_valid, a_op_valid, a_type, a_i, a_j, a_k});
        end
        checks++;
        if ({b_busy, b_valid, b_op_valid, b_type, b_i, b_j, b_k} !== 17'd0) begin
            errors++;
            $display("FAIL reset_b: got %b expected all zero", {b_busy, b_valid, b_op_valid, b_type, b_i, b_j, b_k});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int vt, nx;
        int et[8] = '{0, 2, 0, 3, 0, 3, 0, 3};
        int ei[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        run_stream(1'b0, 1'b0, 0, 1'b0, vt, nx);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (seen[n].t !== et[n] || seen[n].i !== ei[n] || seen[n].j !== 0 || seen[n].k !== 0) begin
                errors++;
                $display("FAIL first_ops[%0d]: got t=%0d i=%0d j=%0d k=%0d expected t=%0d i=%0d j=0 k=0",
                         n, seen[n].t, seen[n].i, seen[n].j, seen[n].k, et[n], ei[n]);
            end
        end
        checks++;
        if (nx != 77) begin errors++; $display("FAIL stream_count: got %0d expected 77", nx); end
        checks++;
        if (vt != 77) begin errors++; $display("FAIL stream_done_time: got %0d expected 77", vt); end
    endtask

    task automatic test_column();
        int vt, nx;
        int ct[4] = '{0, 1, 2, 0};
        int ci[4] = '{1, 1, 1, 2};
        run_stream(1'b0, 1'b0, 0, 1'b0, vt, nx);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (seen[12 + n].t !== ct[n] || seen[12 + n].i !== ci[n] || seen[12 + n].j !== 1 || seen[12 + n].k !== 0) begin
                errors++;
                $display("FAIL col1_op[%0d]: got t=%0d i=%0d j=%0d k=%0d expected t=%0d i=%0d j=1 k=0",
                         13 + n, seen[12 + n].t, seen[12 + n].i, seen[12 + n].j, seen[12 + n].k, ct[n], ci[n]);
            end
        end
        for (int n = 0; n < 7; n++) begin
            checks++;
            if (seen[70 + n].t !== ((n == 0) ? 0 : (n == 6) ? 2 : 1) || seen[70 + n].i !== 5 ||
                seen[70 + n].j !== 5 || seen[70 + n].k !== ((n >= 1 && n <= 5) ? n - 1 : 0)) begin
                errors++;
                $display("FAIL last_col_op[%0d]: got t=%0d i=%0d j=%0d k=%0d", 71 + n,
                         seen[70 + n].t, seen[70 + n].i, seen[70 + n].j, seen[70 + n].k);
            end
        end
    endtask

    task automatic test_backpressure();
        int vt, nx;
        run_stream(1'b0, 1'b1, 0, 1'b0, vt, nx);
        checks++;
        if (nx != 77) begin errors++; $display("FAIL stall_count: got %0d expected 77", nx); end
        checks++;
        if (vt != 153) begin errors++; $display("FAIL stall_done_time: got %0d expected 153", vt); end
    endtask

    task automatic test_start_while_busy();
        int vt, nx;
        run_stream(1'b0, 1'b0, 30, 1'b0, vt, nx);
        checks++;
        if (vt != 77 || nx != 77) begin
            errors++;
            $display("FAIL start_busy: got done=%0d ops=%0d expected 77 and 77", vt, nx);
        end
    endtask

    task automatic test_back_to_back();
        int vt, nx;
        run_stream(1'b0, 1'b0, 0, 1'b1, vt, nx);
        checks++;
        if (vt != 77 || nx != 77) begin
            errors++;
            $display("FAIL b2b_first: got done=%0d ops=%0d expected 77 and 77", vt, nx);
        end
        run_stream(1'b0, 1'b0, 0, 1'b0, vt, nx);
        checks++;
        if (vt != 77 || nx != 77) begin
            errors++;
            $display("FAIL b2b_second: got done=%0d ops=%0d expected 77 and 77", vt, nx);
        end
    endtask

    task automatic test_reset_mid_stream();
        int  vt, nx;
        bit  found;
        sel = 1'b0; start = 1'b1; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int e = 0; e < 200 && !found; e++) begin
            if (v_op_valid && v_type == 2'b01 && v_i == 4'd4 && v_j == 4'd3 && v_k == 4'd1) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_target: got not found expected ACC(4,3,1)"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_op_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: got op_valid=%0b busy=%0b expected 0 0", a_op_valid, a_busy);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (a_valid !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %0b expected 0", a_valid); end
        end
        rst_n = 1'b1;
        run_stream(1'b0, 1'b0, 0, 1'b0, vt, nx);
        checks++;
        if (vt != 77 || nx != 77) begin
            errors++;
            $display("FAIL restart_after_abort: got done=%0d ops=%0d expected 77 and 77", vt, nx);
        end
    endtask

    task automatic test_n12();
        int vt, nx;
        run_stream(1'b1, 1'b0, 0, 1'b0, vt, nx);
        checks++;
        if (nx != 442 || vt != 442) begin
            errors++;
            $display("FAIL n12_counts: got ops=%0d done=%0d expected 442 and 442", nx, vt);
        end
        checks++;
        if (seen[441].t !== 2 || seen[441].i !== 11 || seen[441].j !== 11 ||
            seen[440].t !== 1 || seen[440].i !== 11 || seen[440].j !== 11 || seen[440].k !== 10) begin
            errors++;
            $display("FAIL n12_tail: got last t=%0d i=%0d j=%0d prev t=%0d k=%0d expected DIAG(11,11) after ACC k=10",
                     seen[441].t, seen[441].i, seen[441].j, seen[440].t, seen[440].k);
        end
        sel = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_column();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_stream();
        test_n12();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
